fib_lpm_engine: RTL and testbench

Parametrised longest-prefix-match FIB for the NDN router. It holds a hashed presence bitmap per prefix length and accepts insert/delete requests from the control path. It serves lookups from the PIT by probing from the requested length down to 0. Each result is emitted as a byte-serial packet header toward the SPI transmit path, with ready/valid backpressure.

---
 rtl/fib_pkg.sv | 24 ++
 rtl/fib_hash.sv | 36 +++
 rtl/fib_lpm_engine.sv | 220 ++++++++++++++++++++++
 tb/tb_fib_lpm_engine.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fib_pkg.sv
// rtl/fib_pkg.sv - shared sizes, lookup FSM states and prefix mask helper for the LPM FIB
package fib_pkg;

    localparam int FIB_PREFIX_W = 64;
    localparam int FIB_HASH_W   = 10;
    localparam int FIB_LEN_W    = 7;
    localparam int FIB_META_W   = 8;

    localparam int PFX_BYTES = FIB_PREFIX_W / 8;
    localparam int PKT_BYTES = 2 * PFX_BYTES + 2;

    typedef enum logic [1:0] {
        IDLE,
        HASH,
        PROBE,
        EMIT
    } fib_state_t;

    // Bit pos (0 = LSB) of a width-bit MSB-aligned prefix survives mask(p, len).
    function automatic logic fib_mask_bit(input int pos, input int len, input int width);
        return (len >= width) || (pos >= width - len);
    endfunction

endpackage

// File: rtl/fib_hash.sv
// rtl/fib_hash.sv - registered index hash: XOR-fold of mask(prefix,len) into HASH_W bits, XOR len
module fib_hash
    import fib_pkg::*;
#(
    parameter int PREFIX_W = FIB_PREFIX_W,
    parameter int HASH_W   = FIB_HASH_W,
    parameter int LEN_W    = FIB_LEN_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [PREFIX_W-1:0] prefix,
    input  logic [LEN_W-1:0]    len,
    output logic [HASH_W-1:0]   idx
);

    logic [HASH_W-1:0] fold;

    always_comb begin
        fold = '0;
        for (int i = 0; i < PREFIX_W; i++) begin
            fold[i % HASH_W] = fold[i % HASH_W] ^ (prefix[i] & fib_mask_bit(i, int'(len), PREFIX_W));
        end
        for (int j = 0; j < LEN_W; j++) begin
            fold[j % HASH_W] = fold[j % HASH_W] ^ len[j];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx <= '0;
        end else begin
            idx <= fold;
        end
    end

endmodule

// File: rtl/fib_lpm_engine.sv
// rtl/fib_lpm_engine.sv - hashed-bitmap LPM FIB with byte-serial result packets; FIB_LPM_STATS_EN adds hit/miss counters
module fib_lpm_engine
    import fib_pkg::*;
#(
    parameter int PREFIX_W = FIB_PREFIX_W,
    parameter int HASH_W   = FIB_HASH_W,
    parameter int LEN_W    = FIB_LEN_W,
    parameter int META_W   = FIB_META_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ins_valid,
    output logic                ins_ready,
    input  logic                ins_del,
    input  logic [PREFIX_W-1:0] ins_prefix,
    input  logic [LEN_W-1:0]    ins_len,
    input  logic                lkp_valid,
    output logic                lkp_ready,
    input  logic [PREFIX_W-1:0] lkp_prefix,
    input  logic [LEN_W-1:0]    lkp_len,
    input  logic [META_W-1:0]   lkp_meta,
    output logic                tx_valid,
    input  logic                tx_ready,
    output logic [7:0]          tx_data,
    output logic                tx_last
`ifdef FIB_LPM_STATS_EN
    ,
    output logic [15:0]         hit_count,
    output logic [15:0]         miss_count
`endif
);

    localparam int PFX_B = PREFIX_W / 8;
    localparam int PKT_B = 2 * PFX_B + 2;
    localparam int PKT_W = 8 * PKT_B;
    localparam int ROWS  = PREFIX_W + 1;
    localparam int CNT_W = $clog2(PKT_B);

    localparam logic [LEN_W-1:0] MAX_LEN  = LEN_W'(PREFIX_W);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(PKT_B - 1);

    logic [(1 << HASH_W)-1:0] tbl [ROWS];

    logic              ins_pend;
    logic              ins_del_q;
    logic [LEN_W-1:0]  ins_len_q;
    logic [HASH_W-1:0] ins_idx;
    logic [HASH_W-1:0] lkp_idx;

    fib_state_t          state;
    fib_state_t          state_nxt;
    logic [PREFIX_W-1:0] p_q;
    logic [META_W-1:0]   meta_q;
    logic [LEN_W-1:0]    l_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [PKT_W-1:0]    pkt_q;
    logic                probe_bit;
    logic                probe_done;
    logic [PREFIX_W-1:0] matched;
    logic [7:0]          status;

    fib_hash #(
        .PREFIX_W (PREFIX_W),
        .HASH_W   (HASH_W),
        .LEN_W    (LEN_W)
    ) u_ins_hash (
        .clk    (clk),
        .rst    (rst),
        .prefix (ins_prefix),
        .len    (ins_len),
        .idx    (ins_idx)
    );

    fib_hash #(
        .PREFIX_W (PREFIX_W),
        .HASH_W   (HASH_W),
        .LEN_W    (LEN_W)
    ) u_lkp_hash (
        .clk    (clk),
        .rst    (rst),
        .prefix (p_q),
        .len    (l_q),
        .idx    (lkp_idx)
    );

    // Insert pipe: the hash registers on the accept edge, the write lands one edge later.
    assign ins_ready = ~ins_pend;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ins_pend  <= 1'b0;
            ins_del_q <= 1'b0;
            ins_len_q <= '0;
        end else if (ins_valid && ins_ready) begin
            ins_pend  <= 1'b1;
            ins_del_q <= ins_del;
            ins_len_q <= ins_len;
        end else begin
            ins_pend  <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < ROWS; r++) begin
                tbl[r] <= '0;
            end
        end else if (ins_pend && (ins_len_q <= MAX_LEN)) begin
            tbl[ins_len_q][ins_idx] <= ~ins_del_q;
        end
    end

    // Read is combinational against the pre-edge table, so a same-cycle write is not seen.
    assign probe_bit  = tbl[l_q][lkp_idx];
    assign probe_done = probe_bit || (l_q == '0);
    assign status     = {probe_bit, 7'(l_q)};

    always_comb begin
        matched = '0;
        for (int i = 0; i < PREFIX_W; i++) begin
            matched[i] = probe_bit & p_q[i] & fib_mask_bit(i, int'(l_q), PREFIX_W);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        lkp_ready = 1'b0;
        tx_valid  = 1'b0;
        tx_data   = '0;
        tx_last   = 1'b0;
        case (state)
            IDLE: begin
                lkp_ready = 1'b1;
                if (lkp_valid) begin
                    state_nxt = HASH;
                end
            end
            HASH: begin
                state_nxt = PROBE;
            end
            PROBE: begin
                state_nxt = probe_done ? EMIT : HASH;
            end
            EMIT: begin
                tx_valid = 1'b1;
                tx_data  = pkt_q[PKT_W-1 -: 8];
                tx_last  = (cnt_q == LAST_CNT);
                if (tx_ready && (cnt_q == LAST_CNT)) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // The whole packet is assembled once and shifted out MSB byte first.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p_q    <= '0;
            meta_q <= '0;
            l_q    <= '0;
            cnt_q  <= '0;
            pkt_q  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (lkp_valid) begin
                        p_q    <= lkp_prefix;
                        meta_q <= lkp_meta;
                        l_q    <= (lkp_len > MAX_LEN) ? MAX_LEN : lkp_len;
                    end
                end
                PROBE: begin
                    if (probe_done) begin
                        pkt_q <= {8'(meta_q), p_q, matched, status};
                        cnt_q <= '0;
                    end else begin
                        l_q <= l_q - LEN_W'(1);
                    end
                end
                EMIT: begin
                    if (tx_ready) begin
                        pkt_q <= pkt_q << 8;
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef FIB_LPM_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else if ((state == PROBE) && probe_done) begin
            if (probe_bit) begin
                if (hit_count != 16'hFFFF) begin
                    hit_count <= hit_count + 16'd1;
                end
            end else if (miss_count != 16'hFFFF) begin
                miss_count <= miss_count + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fib_lpm_engine.sv
// tb/tb_fib_lpm_engine.sv - randomized scoreboard bench for fib_lpm_engine against a set-based FIB model
`timescale 1ns/1ps
module tb_fib_lpm_engine;
    import fib_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ins_valid = 1'b0;
    logic        ins_ready;
    logic        ins_del = 1'b0;
    logic [63:0] ins_prefix = '0;
    logic [6:0]  ins_len = '0;
    logic        lkp_valid = 1'b0;
    logic        lkp_ready;
    logic [63:0] lkp_prefix = '0;
    logic [6:0]  lkp_len = '0;
    logic [7:0]  lkp_meta = '0;
    logic        tx_valid;
    logic        tx_ready = 1'b1;
    logic [7:0]  tx_data;
    logic        tx_last;
`ifdef FIB_LPM_STATS_EN
    logic [15:0] hit_count;
    logic [15:0] miss_count;
`endif

    fib_lpm_engine dut (
        .clk        (clk),
        .rst        (rst),
        .ins_valid  (ins_valid),
        .ins_ready  (ins_ready),
        .ins_del    (ins_del),
        .ins_prefix (ins_prefix),
        .ins_len    (ins_len),
        .lkp_valid  (lkp_valid),
        .lkp_ready  (lkp_ready),
        .lkp_prefix (lkp_prefix),
        .lkp_len    (lkp_len),
        .lkp_meta   (lkp_meta),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .tx_data    (tx_data),
        .tx_last    (tx_last)
`ifdef FIB_LPM_STATS_EN
        ,
        .hit_count  (hit_count),
        .miss_count (miss_count)
`endif
    );

    initial forever #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int rmode    = 0;
    logic [8:0] exp_q [$];
    bit fib_set [int];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [63:0] m_mask(input logic [63:0] p, input int len);
        if (len <= 0) return 64'd0;
        if (len >= 64) return p;
        return p & ~((64'd1 << (64 - len)) - 64'd1);
    endfunction

    function automatic int m_hash(input logic [63:0] p, input int len);
        logic [63:0] m;
        int h;
        m = m_mask(p, len);
        h = 0;
        for (int i = 0; i < 64; i++) if (m[i]) h = h ^ (1 << (i % 10));
        return (h ^ len) & 1023;
    endfunction

    function automatic int m_key(input logic [63:0] p, input int len);
        return len * 1024 + m_hash(p, len);
    endfunction

    // tx_ready pattern: 0 = always ready, 1 = toggle each cycle, 2 = random
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (rmode)
                0: tx_ready = 1'b1;
                1: tx_ready = ~tx_ready;
                default: tx_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (!rst && tx_valid) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL tx_unexpected: got byte %0h expected none", tx_data);
                end else begin
                    check("tx_data", tx_data, exp_q[0][7:0]);
                    check("tx_last", tx_last, exp_q[0][8]);
                    if (tx_ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    task automatic check_reset_vals();
        check("rst_ins_ready", ins_ready, 1);
        check("rst_lkp_ready", lkp_ready, 1);
        check("rst_tx_valid", tx_valid, 0);
        check("rst_tx_data", tx_data, 0);
        check("rst_tx_last", tx_last, 0);
    endtask

    task automatic do_insert(input logic [63:0] p, input int len, input bit del);
        int cyc;
        bit acc;
        cyc = 0;
        ins_prefix = p;
        ins_len    = 7'(len);
        ins_del    = del;
        ins_valid  = 1'b1;
        do begin
            acc = ins_ready;
            @(posedge clk);
            cyc++;
        end while (!acc && cyc < 10);
        #1;
        ins_valid = 1'b0;
        check("ins_busy", ins_ready, 0);
        if (len <= 64) begin
            if (del) fib_set.delete(m_key(p, len));
            else fib_set[m_key(p, len)] = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_lookup(input logic [63:0] p, input int len, input logic [7:0] meta);
        int l0, lh, probes, cyc;
        bit hit;
        logic [63:0] mt;
        l0 = (len > 64) ? 64 : len;
        hit = 1'b0;
        lh = 0;
        for (int l = l0; l >= 0; l--) begin
            if (fib_set.exists(m_key(p, l))) begin
                hit = 1'b1;
                lh = l;
                break;
            end
        end
        probes = hit ? (l0 - lh + 1) : (l0 + 1);
        mt = hit ? m_mask(p, lh) : 64'd0;
        exp_q.push_back({1'b0, meta});
        for (int i = 0; i < 8; i++) exp_q.push_back({1'b0, 8'(p >> (56 - 8 * i))});
        for (int i = 0; i < 8; i++) exp_q.push_back({1'b0, 8'(mt >> (56 - 8 * i))});
        exp_q.push_back({1'b1, hit, 7'(lh)});

        cyc = 0;
        while (!lkp_ready && cyc < 400) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        lkp_prefix = p;
        lkp_len    = 7'(len);
        lkp_meta   = meta;
        lkp_valid  = 1'b1;
        @(posedge clk);
        #1;
        lkp_valid = 1'b0;
        cyc = 0;
        while (!tx_valid && cyc < 300) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check("first_byte_latency", cyc, 2 * probes);
        cyc = 0;
        while (exp_q.size() != 0 && cyc < 400) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check("packet_drained", exp_q.size(), 0);
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        logic [63:0] name;
        logic [63:0] pool [4];

        repeat (3) @(posedge clk);
        #1;
        check_reset_vals();
        rst = 1'b0;
        @(posedge clk);
        #1;

        name = 64'h0102030405060708;
        do_lookup(name, 64, 8'hA5);
        do_insert(64'h0102000000000000, 16, 1'b0);
        do_lookup(name, 64, 8'h11);
        do_insert(name, 16, 1'b0);
        do_insert(name, 32, 1'b0);
        do_lookup(name, 64, 8'h22);
        do_insert(name, 32, 1'b1);
        do_lookup(name, 64, 8'h33);
        do_insert(64'd0, 0, 1'b0);
        do_lookup(64'hFFFFFFFFFFFFFFFF, 8, 8'h44);
        do_insert(name, 70, 1'b0);
        do_lookup(name, 127, 8'h55);

        rmode = 1;
        do_lookup(name, 40, 8'h66);

        fork
            do_lookup(name, 20, 8'h3C);
            begin
                repeat (3) @(posedge clk);
                #2;
                do_insert(64'hDEADBEEF00000000, 50, 1'b0);
            end
        join

        for (int k = 0; k < 4; k++) pool[k] = {$urandom, $urandom};
        for (int it = 0; it < 60; it++) begin
            rmode = $urandom_range(0, 2);
            if ($urandom_range(0, 2) == 0)
                do_insert(pool[$urandom_range(0, 3)], $urandom_range(0, 70), 1'($urandom_range(0, 3) == 0));
            else
                do_lookup(pool[$urandom_range(0, 3)] ^ 64'($urandom_range(0, 255)),
                          $urandom_range(0, 127), 8'($urandom));
        end

        rmode = 0;
        name = 64'h1122334455667788;
        do_insert(name, 16, 1'b0);
        lkp_prefix = name;
        lkp_len    = 7'd64;
        lkp_meta   = 8'h77;
        lkp_valid  = 1'b1;
        @(posedge clk);
        #1;
        lkp_valid = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        ins_prefix = name;
        ins_len    = 7'd24;
        ins_del    = 1'b0;
        ins_valid  = 1'b1;
        @(posedge clk);
        #1;
        ins_valid = 1'b0;
        rst = 1'b1;
        #1;
        exp_q.delete();
        fib_set.delete();
        check_reset_vals();
        @(posedge clk);
        #1;
        check_reset_vals();
        rst = 1'b0;
        @(posedge clk);
        #1;
        do_lookup(name, 64, 8'h88);
        do_lookup(name, 24, 8'h99);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
